// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, the byte-array view of a state,
// and the row/column to byte-position mapping used by the round stages.
package aes_pkg;

  // Width of one AES state in bits and the number of bytes it holds.
  localparam int STATE_W   = 128;
  localparam int NUM_BYTES = 16;
  localparam int NUM_ROWS  = 4;
  localparam int NUM_COLS  = 4;

  // One AES state viewed as 16 bytes. The range is ascending so that index 0
  // is the most significant byte, which lines up with a [0:127] bus where
  // bit 0 is the MSB of byte 0.
  typedef logic [0:NUM_BYTES-1][7:0] aes_state_t;

  // Byte position of matrix element (row, col) in column-major FIPS-197 order.
  function automatic int byte_index(input int row, input int col);
    return row + NUM_ROWS * col;
  endfunction

endpackage

// File: rtl/inverse_shift_rows_comb.sv
// Combinational AES inverse ShiftRows: row r of the 4x4 byte matrix is
// rotated right by r positions. Pure wiring, no register, so an unrolled or
// iterative decryptor can drop it straight into its own datapath.
module inverse_shift_rows_comb
  import aes_pkg::*;
(
  input  logic [0:STATE_W-1] in,
  output logic [0:STATE_W-1] out
);

  aes_state_t in_s;
  aes_state_t out_s;

  assign in_s = in;
  assign out  = out_s;

  // out(r, c) takes in(r, (c - r) mod 4); the +NUM_COLS keeps the modulo
  // operand non-negative. Indices are elaboration-time constants.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      localparam int DST = byte_index(r, c);
      localparam int SRC = byte_index(r, (c - r + NUM_COLS) % NUM_COLS);
      assign out_s[DST] = in_s[SRC];
    end
  end

endmodule

// File: rtl/inverse_shift_rows.sv
// Registered AES inverse ShiftRows stage: one state in per cycle, the
// permuted state appears on `out` one clock later.
//
// Handshake: valid-only, no ready. in_valid=1 at a rising edge means `in`
// is consumed at that edge; out_valid=1 for exactly the cycle after each
// such edge. The downstream stage must take every result. When in_valid=0
// the last result stays on `out` but out_valid drops. rst has priority and
// clears both the data and the valid flag, discarding anything in flight.
module inverse_shift_rows
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [0:STATE_W-1] in,
  output logic               out_valid,
  output logic [0:STATE_W-1] out
);

  logic [0:STATE_W-1] permuted;

  inverse_shift_rows_comb u_comb (
    .in  (in),
    .out (permuted)
  );

  // Output register: load the permuted state on valid input, hold it
  // otherwise; the valid flag simply follows in_valid by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= permuted;
      end
    end
  end

endmodule

// File: tb/tb_inverse_shift_rows.sv
// Self-checking bench for inverse_shift_rows: row-rotation reference model,
// every-cycle compare process, and literal vectors pinning the model.
module tb_inverse_shift_rows;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [0:127] in_data;
  logic         out_valid;
  logic [0:127] out;

  int tests;
  int fails;

  logic         check_en;
  logic         exp_valid;
  logic [0:127] exp_out;
  logic [127:0] exp_q[$];

  inverse_shift_rows dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in_data),
    .out_valid (out_valid),
    .out       (out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: split into a 4x4 matrix, rotate row r right r times.
  function automatic logic [0:127] inv_ref(input logic [0:127] v);
    logic [7:0] m[4][4];
    logic [7:0] t;
    logic [0:127] o;
    for (int k = 0; k < 16; k++) m[k % 4][k / 4] = v[8*k +: 8];
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < r; n++) begin
        t = m[r][3]; m[r][3] = m[r][2]; m[r][2] = m[r][1]; m[r][1] = m[r][0]; m[r][0] = t;
      end
    end
    for (int k = 0; k < 16; k++) o[8*k +: 8] = m[k % 4][k / 4];
    return o;
  endfunction

  // Forward ShiftRows: rotate row r left r times.
  function automatic logic [0:127] fwd_ref(input logic [0:127] v);
    logic [7:0] m[4][4];
    logic [7:0] t;
    logic [0:127] o;
    for (int k = 0; k < 16; k++) m[k % 4][k / 4] = v[8*k +: 8];
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < r; n++) begin
        t = m[r][0]; m[r][0] = m[r][1]; m[r][1] = m[r][2]; m[r][2] = m[r][3]; m[r][3] = t;
      end
    end
    for (int k = 0; k < 16; k++) o[8*k +: 8] = m[k % 4][k / 4];
    return o;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check128(input string name, input logic [0:127] act, input logic [0:127] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Behavioural model of the output register, advanced at each edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_out   = '0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = in_valid;
      if (in_valid) exp_out = inv_ref(in_data);
    end
  end

  // Compare process: every cycle once reset has been applied.
  always @(negedge clk) begin
    if (check_en) begin
      check1("cyc_valid", out_valid, exp_valid);
      check128("cyc_out", out, exp_out);
    end
  end

  // driver: present inputs for one edge, return #1 after it
  task automatic drive(input logic r, input logic v, input logic [0:127] d);
    rst      = r;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  logic [0:127] orig;
  logic [0:127] ones;

  initial begin
    tests    = 0;
    fails    = 0;
    check_en = 1'b0;
    ones     = '1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = rand128();
    @(negedge clk);

    // Model pins against hand-computed vectors.
    check128("model_index", inv_ref(128'h000102030405060708090a0b0c0d0e0f),
             128'h000d0a0704010e0b0805020f0c090603);
    check128("model_vec_a", inv_ref(128'hbdb52189f261b63d0b107c9e8b6e776e),
             128'hbd6e7c3df2b5779e0b61216e8b10b689);
    check128("model_fwd_inv", fwd_ref(128'h000d0a0704010e0b0805020f0c090603),
             128'h000102030405060708090a0b0c0d0e0f);

    // Reset with valid input and random data: outputs must stay cleared.
    drive(1'b1, 1'b1, rand128());
    check_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, rand128());
      check128("reset_out", out, 128'h0);
      check1("reset_valid", out_valid, 1'b0);
    end
    drive(1'b0, 1'b0, rand128());
    check1("post_reset_idle", out_valid, 1'b0);

    // Directed vectors, literal expectations through a scoreboard queue.
    exp_q.push_back(128'h000d0a0704010e0b0805020f0c090603);
    exp_q.push_back(128'hbd6e7c3df2b5779e0b61216e8b10b689);
    exp_q.push_back(128'hfde3bad205e5d0d73547964ef1fe37f1);
    drive(1'b0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
    check128("index_out", out, exp_q.pop_front());
    check1("index_valid", out_valid, 1'b1);
    drive(1'b0, 1'b1, 128'hbdb52189f261b63d0b107c9e8b6e776e);
    check128("vec_a_out", out, exp_q.pop_front());
    check1("vec_a_valid", out_valid, 1'b1);
    drive(1'b0, 1'b1, 128'hfde596f1054737d235febad7f1e3d04e);
    check128("vec_b_out", out, exp_q.pop_front());
    check1("vec_b_valid", out_valid, 1'b1);
    drive(1'b0, 1'b0, ones);
    check128("hold_out", out, 128'hfde3bad205e5d0d73547964ef1fe37f1);
    check1("hold_valid", out_valid, 1'b0);

    // Inverse property on random states, then the fixed points.
    for (int i = 0; i < 9; i++) begin
      orig = rand128();
      drive(1'b0, 1'b1, fwd_ref(orig));
      check128("inverse_prop", out, orig);
    end
    drive(1'b0, 1'b1, '0);
    check128("all_zero", out, 128'h0);
    drive(1'b0, 1'b1, ones);
    check128("all_ones", out, ones);

    // Random stream with gaps and occasional mid-stream reset.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), rand128());
    end
    drive(1'b0, 1'b0, rand128());

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
